// File: rtl/spi_reg_bank_sync.sv
// spi_reg_bank_sync: oversampled SPI-slave control-register bank with set/clear/toggle and read-back
module spi_reg_bank_sync #(
  parameter int NREG = 16,
  parameter int RW = 8,
  parameter logic [RW-1:0] RESET_VAL = '0,
  parameter int ERR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_clk,
  input  logic                 spi_cs,
  input  logic                 spi_din,
  output logic                 spi_dout,
  output logic [NREG*RW-1:0]   reg_out,
  output logic                 wr_stb,
  output logic [5:0]           wr_addr,
  output logic [ERR_W-1:0]     err_cnt
);
  localparam int FRAME = 8 + 2 * RW;
  localparam int CW = $clog2(FRAME + 2);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t r_state, w_next;
  logic [2:0] r_clk_s, r_cs_s, r_din_s;
  logic [1:0] r_settle;
  logic r_armed;
  logic [FRAME-1:0] r_sr;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_tx;
  logic r_dout;
  logic [NREG*RW-1:0] r_bank;
  logic r_stb;
  logic [5:0] r_waddr;
  logic [ERR_W-1:0] r_err;
  logic w_cs_fall, w_cs_rise, w_clk_fall, w_clk_rise, w_din;
  logic w_start, w_sample, w_drive, w_commit;
  logic [FRAME-1:0] w_sr_next;
  logic [1:0] w_op;
  logic [5:0] w_cmd_addr;
  logic [RW-1:0] w_set, w_clr, w_cur, w_new, w_rd;
  logic w_full, w_in_range, w_accept, w_err;
  function automatic logic [RW-1:0] f_rd(input logic [5:0] addr, input logic [NREG*RW-1:0] bank);
    logic [RW-1:0] v;
    v = '0;
    for (int k = 0; k < NREG; k++) if (addr == 6'(k)) v = bank[k*RW +: RW];
    return v;
  endfunction
  assign w_cs_fall  = ~r_cs_s[1] & r_cs_s[2] & r_armed;
  assign w_cs_rise  = r_cs_s[1] & ~r_cs_s[2];
  assign w_clk_fall = ~r_clk_s[1] & r_clk_s[2];
  assign w_clk_rise = r_clk_s[1] & ~r_clk_s[2];
  assign w_din      = r_din_s[2];
  assign w_sr_next  = {r_sr[FRAME-2:0], w_din};
  assign w_op       = r_sr[FRAME-1 -: 2];
  assign w_cmd_addr = r_sr[FRAME-3 -: 6];
  assign w_set      = r_sr[RW +: RW];
  assign w_clr      = r_sr[RW-1:0];
  assign w_full     = r_cnt == CW'(FRAME);
  assign w_in_range = 32'(w_cmd_addr) < NREG;
  assign w_accept   = w_commit & w_full & (w_op == 2'b01 | w_op == 2'b10) & w_in_range;
  assign w_err      = w_commit & ~w_full;
  assign spi_dout   = r_dout;
  assign reg_out    = r_bank;
  assign wr_stb     = r_stb;
  assign wr_addr    = r_waddr;
  assign err_cnt    = r_err;
  // Synchronise pins; a frame already running at reset release stays disarmed until cs is seen high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clk_s  <= 3'b000;
      r_cs_s   <= 3'b111;
      r_din_s  <= 3'b000;
      r_settle <= 2'd0;
      r_armed  <= 1'b0;
    end else begin
      r_clk_s  <= {r_clk_s[1:0], spi_clk};
      r_cs_s   <= {r_cs_s[1:0], spi_cs};
      r_din_s  <= {r_din_s[1:0], spi_din};
      r_settle <= r_settle + 2'(r_settle != 2'd2);
      r_armed  <= r_armed | (r_settle == 2'd2 & r_cs_s[1]);
    end
  end
  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next state and datapath strobes; clk edges are only honoured inside a frame
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_sample = 1'b0;
    w_drive  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = w_cs_fall;
        w_next  = w_cs_fall ? SHIFT : IDLE;
      end
      SHIFT: begin
        w_commit = w_cs_rise;
        w_sample = ~w_cs_rise & w_clk_fall;
        w_drive  = ~w_cs_rise & w_clk_rise;
        w_next   = w_cs_rise ? COMMIT : SHIFT;
      end
      default: w_next = IDLE;
    endcase
  end
  // Register reads for modify and for the MISO load after the command byte
  always_comb begin
    w_cur = f_rd(w_cmd_addr, r_bank);
    w_rd  = f_rd(w_sr_next[5:0], r_bank);
    w_new = w_op[1] ? (((w_cur | w_set) & ~w_clr) | (w_set & w_clr & ~w_cur)) : w_set;
  end
  // MOSI shift/count on spi_clk fall, MISO shift on spi_clk rise
  always_ff @(posedge clk) begin
    if (!rst_n || w_start) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_tx   <= '0;
      r_dout <= 1'b0;
    end else begin
      if (w_sample) begin
        r_sr  <= w_sr_next;
        r_cnt <= r_cnt + CW'(r_cnt != CW'(FRAME + 1));
        if (r_cnt == CW'(7)) r_tx <= w_rd;
      end
      if (w_drive) begin
        r_dout <= r_tx[RW-1];
        r_tx   <= r_tx << 1;
      end
    end
  end
  // Register bank, updated when a well-formed write or modify frame ends
  always_ff @(posedge clk) begin
    if (!rst_n) r_bank <= {NREG{RESET_VAL}};
    else if (w_accept)
      for (int k = 0; k < NREG; k++) if (w_cmd_addr == 6'(k)) r_bank[k*RW +: RW] <= w_new;
  end
  // Commit strobe, last committed address and saturating frame-error counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stb   <= 1'b0;
      r_waddr <= 6'd0;
      r_err   <= '0;
    end else begin
      r_stb <= w_accept;
      if (w_accept) r_waddr <= w_cmd_addr;
      if (w_err && !(&r_err)) r_err <= r_err + 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_reg_bank_sync.sv
// tb_spi_reg_bank_sync: directed SPI frames with a commit scoreboard and direct status checks
module tb_spi_reg_bank_sync;
  localparam int NREG = 16;
  localparam int RW = 8;
  typedef struct {
    logic [5:0] addr;
    logic [7:0] val;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, spi_clk = 1'b0, spi_cs = 1'b1, spi_din = 1'b0;
  logic spi_dout, wr_stb;
  logic [NREG*RW-1:0] reg_out;
  logic [5:0] wr_addr;
  logic [7:0] err_cnt;
  logic [39:0] miso_w;
  logic [7:0] model [NREG];
  exp_t exp_q [$];
  int checks = 0, errors = 0, h = 4;
  spi_reg_bank_sync #(.NREG(NREG), .RW(RW), .RESET_VAL(8'h00), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_din(spi_din),
    .spi_dout(spi_dout), .reg_out(reg_out), .wr_stb(wr_stb), .wr_addr(wr_addr), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  function automatic logic [127:0] bank();
    logic [127:0] b;
    b = '0;
    for (int k = 0; k < NREG; k++) b[k*RW +: RW] = model[k];
    return b;
  endfunction
  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [39:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      spi_clk = 1'b1;
      spi_din = bits[n-1-i];
      ticks(h);
      miso_w = {miso_w[38:0], spi_dout};
      spi_clk = 1'b0;
      ticks(h);
    end
  endtask
  task automatic frame(input logic [39:0] bits, input int n);
    miso_w = '0;
    spi_cs = 1'b0;
    ticks(h);
    send(bits, n);
    spi_cs = 1'b1;
    ticks(8);
  endtask
  task automatic expect_wr(input logic [5:0] a, input logic [7:0] v);
    exp_t e;
    e.addr = a;
    e.val = v;
    exp_q.push_back(e);
    model[a] = v;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) ticks(1);
    chk("drain", 128'(exp_q.size()), 128'd0);
  endtask
  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      if (exp_q.size() == 0) chk("unexpected_stb", 128'(wr_stb), 128'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_addr", 128'(wr_addr), 128'(e.addr));
        chk("commit_val", 128'(reg_out[e.addr*RW +: RW]), 128'(e.val));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < NREG; k++) model[k] = 8'h00;
    ticks(4);
    rst_n = 1'b1;
    ticks(6);
    chk("rst_regs", 128'(reg_out), bank());
    chk("rst_err", 128'(err_cnt), 128'd0);
    chk("rst_stb", 128'(wr_stb), 128'd0);
    chk("rst_waddr", 128'(wr_addr), 128'd0);
    chk("rst_dout", 128'(spi_dout), 128'd0);
    expect_wr(6'd3, 8'hA5);
    frame(40'h43A500, 24);
    drain();
    chk("write3", 128'(reg_out), bank());
    expect_wr(6'd3, 8'h8B);
    frame(40'h830F3C, 24);
    drain();
    chk("modify3", 128'(reg_out), bank());
    frame(40'h030000, 24);
    chk("read3_miso", 128'(miso_w[23:0]), 128'h008B00);
    chk("read3_regs", 128'(reg_out), bank());
    chk("read3_waddr", 128'(wr_addr), 128'd3);
    frame(40'h227F80, 23);
    chk("short_err", 128'(err_cnt), 128'd1);
    frame(40'h0089FE00, 25);
    chk("long_err", 128'(err_cnt), 128'd2);
    chk("badlen_regs", 128'(reg_out), bank());
    frame(40'hC4FF00, 24);
    chk("reserved_err", 128'(err_cnt), 128'd2);
    chk("reserved_regs", 128'(reg_out), bank());
    expect_wr(6'd5, 8'h5A);
    frame(40'h455A00, 24);
    drain();
    chk("write5", 128'(reg_out), bank());
    miso_w = '0;
    spi_cs = 1'b0;
    ticks(h);
    send(40'h461, 12);
    rst_n = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    for (int k = 0; k < NREG; k++) model[k] = 8'h00;
    ticks(1);
    chk("midrst_regs", 128'(reg_out), bank());
    chk("midrst_err", 128'(err_cnt), 128'd0);
    send(40'h100, 12);
    spi_cs = 1'b1;
    ticks(8);
    chk("ignored_regs", 128'(reg_out), bank());
    chk("ignored_err", 128'(err_cnt), 128'd0);
    expect_wr(6'd6, 8'h33);
    frame(40'h463300, 24);
    drain();
    chk("after_rst_write6", 128'(reg_out), bank());
    h = 3;
    frame(40'h547700, 24);
    chk("oor_write_regs", 128'(reg_out), bank());
    chk("oor_write_err", 128'(err_cnt), 128'd0);
    frame(40'h140000, 24);
    chk("oor_read_miso", 128'(miso_w[23:0]), 128'd0);
    expect_wr(6'd15, 8'hC3);
    frame(40'h4FC300, 24);
    drain();
    chk("write15", 128'(reg_out), bank());
    frame(40'h0F0000, 24);
    chk("read15_miso", 128'(miso_w[23:0]), 128'h00C300);
    frame(40'h063300, 24);
    chk("read6_miso", 128'(miso_w[23:0]), 128'h003300);
    chk("fast_err", 128'(err_cnt), 128'd0);
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
